// File: rtl/recv_word_buffer.sv
// recv_word_buffer
//   Input stage for the core's recv_data/recv_valid/readflag interface.
//   Bytes from the serial receiver go into a circular FIFO. A CPU read
//   request returns either one zero-extended byte or one 32-bit word built
//   from four bytes, followed by a single-cycle recv_valid pulse. The core
//   stalls while readflag != 0, so no further handshake is required.
//
//   Build option: define RECV_LITTLE_ENDIAN_EN to assemble words
//   little-endian (first byte received lands in [7:0]). The default build
//   assembles big-endian (first byte received lands in [31:24]).
//
// Ports
//   clk         in   1             clock, rising edge
//   reset       in   1             synchronous, active-high
//   rx_data     in   8             byte from serial receiver
//   rx_valid    in   1             strobe: rx_data valid this cycle
//   readflag    in   2             00 none, 01 word, 10/11 byte
//   recv_data   out  32            read result, meaningful while recv_valid=1
//   recv_valid  out  1             one-cycle pulse: recv_data valid
//   fifo_count  out  DEPTH_LOG2+1  bytes currently buffered (0..DEPTH)
//   overflow    out  1             sticky: a byte was dropped while full
module recv_word_buffer #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic [1:0]            readflag,
  output logic [31:0]           recv_data,
  output logic                  recv_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_COUNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GATHER, RESP, RELEASE} state_t;

  // FIFO storage and pointers
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  overflow_reg;

  // Read assembly
  state_t                state_reg;
  logic [31:0]           asm_reg;
  logic [2:0]            need_reg;
  logic [2:0]            cnt_reg;
  logic [31:0]           recv_data_reg;
  logic                  recv_valid_reg;

  logic                  push;
  logic                  pop;
  logic [7:0]            head_byte;
  logic [31:0]           asm_next;
  logic [2:0]            cnt_next;

  // Head byte is read combinationally so GATHER can consume one byte per
  // cycle; a freshly written byte becomes visible the cycle after its write.
  assign head_byte = mem[rd_ptr_reg];
  assign push      = rx_valid && (count_reg != FULL_COUNT);
  assign pop       = (state_reg == GATHER) && (count_reg != '0);
  assign cnt_next  = cnt_reg + 3'd1;

`ifdef RECV_LITTLE_ENDIAN_EN
  assign asm_next = {head_byte, asm_reg[31:8]};
`else
  assign asm_next = {asm_reg[23:0], head_byte};
`endif

  // Storage array carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count_reg <= count_reg + ONE_COUNT;
        2'b01:   count_reg <= count_reg - ONE_COUNT;
        default: count_reg <= count_reg;
      endcase
      if (rx_valid && !push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      asm_reg        <= '0;
      need_reg       <= '0;
      cnt_reg        <= '0;
      recv_data_reg  <= '0;
      recv_valid_reg <= 1'b0;
    end else begin
      recv_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (readflag != 2'b00) begin
            need_reg  <= (readflag == 2'b01) ? 3'd4 : 3'd1;
            asm_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= GATHER;
          end
        end
        GATHER: begin
          if (pop) begin
            asm_reg <= asm_next;
            cnt_reg <= cnt_next;
            // Result and pulse are registered on the final pop so they
            // appear together with the RESP state.
            if (cnt_next == need_reg) begin
              state_reg      <= RESP;
              recv_valid_reg <= 1'b1;
              recv_data_reg  <= (need_reg == 3'd4) ? asm_next : {24'b0, head_byte};
            end
          end
        end
        RESP: begin
          state_reg <= RELEASE;
        end
        RELEASE: begin
          // A held readflag must not start a second read.
          if (readflag == 2'b00) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign recv_data  = recv_data_reg;
  assign recv_valid = recv_valid_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_recv_word_buffer.sv
// Directed bench for recv_word_buffer: word/byte reads, empty-FIFO wait,
// held readflag, concurrent push/pop, overflow with full read-back and
// reset during a word gather.
module tb_recv_word_buffer;

  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic [1:0]          readflag = 2'b00;
  logic [31:0]         recv_data;
  logic                recv_valid;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overflow;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  recv_word_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .readflag   (readflag),
    .recv_data  (recv_data),
    .recv_valid (recv_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
`ifdef RECV_LITTLE_ENDIAN_EN
    return {b3, b2, b1, b0};
`else
    return {b0, b1, b2, b3};
`endif
  endfunction

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Ticks until recv_valid is seen or max cycles elapse; lat = cycles taken.
  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    while (!recv_valid && lat < max) begin
      tick();
      lat++;
    end
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp);
    int lat;
    readflag = 2'b01;
    wait_valid(20, lat);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_data"}, recv_data, exp);
    readflag = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] held;
    logic [7:0] extra [4];
    extra[0] = 8'h55; extra[1] = 8'h66; extra[2] = 8'h77; extra[3] = 8'h88;

    // Reset state
    tick();
    tick();
    check("rst_recv_valid", recv_valid, 0);
    check("rst_recv_data", recv_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    // Word read with data buffered, readflag held past the pulse
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    check("w1_count_before", fifo_count, 4);
    readflag = 2'b01;
    wait_valid(20, lat);
    check("w1_lat", lat, 5);
    check("w1_data", recv_data, exp_word(8'h12, 8'h34, 8'h56, 8'h78));
    check("w1_count_after", fifo_count, 0);
    held = recv_data;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (recv_valid) pulses++;
    end
    check("w1_extra_pulses", pulses, 0);
    check("w1_data_hold", recv_data, held);
    readflag = 2'b00;
    tick();
    tick();

    // Byte read from empty FIFO, byte arrives 10 cycles later
    readflag = 2'b10;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (recv_valid) pulses++;
    end
    check("b_empty_no_pulse", pulses, 0);
    push_byte(8'hA5);
    check("b_empty_valid_push+1", recv_valid, 0);
    tick();
    check("b_empty_valid_push+2", recv_valid, 1);
    check("b_empty_data", recv_data, 32'h000000A5);
    readflag = 2'b00;
    tick();
    tick();

    // Held byte request with 2 bytes buffered: exactly one pulse
    push_byte(8'h9A); push_byte(8'hBC);
    readflag = 2'b10;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (recv_valid) pulses++;
    end
    check("held_pulses", pulses, 1);
    check("held_count", fifo_count, 1);
    readflag = 2'b00;
    tick();
    tick();
    readflag = 2'b10;
    wait_valid(20, lat);
    check("held_next_lat", lat, 2);
    check("held_next_data", recv_data, 32'h000000BC);
    readflag = 2'b00;
    tick();
    tick();
    check("held_drained", fifo_count, 0);

    // Push during every pop of a word read
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    readflag = 2'b01;
    tick();
    check("pp_count_enter", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      rx_data  = extra[i];
      rx_valid = 1'b1;
      tick();
      check($sformatf("pp_count_%0d", i), fifo_count, 4);
    end
    rx_valid = 1'b0;
    check("pp_valid", recv_valid, 1);
    check("pp_data", recv_data, exp_word(8'h11, 8'h22, 8'h33, 8'h44));
    readflag = 2'b00;
    tick();
    tick();
    read_word("pp_second", exp_word(8'h55, 8'h66, 8'h77, 8'h88));
    check("pp_drained", fifo_count, 0);

    // Overflow: DEPTH+3 pushes, then read DEPTH bytes back in order
    for (int i = 0; i < DEPTH + 3; i++) begin
      push_byte(8'(i));
    end
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_flag", overflow, 1);
    for (int w = 0; w < DEPTH / 4; w++) begin
      read_word($sformatf("ovf_word_%0d", w),
                exp_word(8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)));
    end
    check("ovf_drained", fifo_count, 0);
    check("ovf_sticky", overflow, 1);

    // Reset in the middle of a word gather
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    readflag = 2'b01;
    tick();
    tick();
    tick();
    check("mid_count_2pops", fifo_count, 2);
    reset    = 1'b1;
    readflag = 2'b00;
    tick();
    reset = 1'b0;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_valid", recv_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    check("mid_count_new", fifo_count, 4);
    read_word("mid_fresh", exp_word(8'hC1, 8'hC2, 8'hC3, 8'hC4));
    check("mid_drained", fifo_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
